// File: rtl/fp32_seq_pkg.sv
// Shared types and constants for the FP32 MAC byte-stream sequencer.
package fp32_seq_pkg;

  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    FIRE      = 3'd1,
    WAIT_DONE = 3'd2,
    SEND      = 3'd3,
    WAIT_TX   = 3'd4
  } seq_state_e;

  localparam int OPERAND_BYTES = 12;
  localparam int RESULT_BYTES  = 4;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/posedge_detector.sv
// Registers a level input and flags the cycle in which it has just gone 0 -> 1.
module posedge_detector (
  input  logic CLK_I,
  input  logic RSTL_I,
  input  logic SIG_I,
  output logic EDGE_O
);

  logic cur_q;
  logic prev_q;

  // Two-stage history of the level: current sample and the one before it.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= SIG_I;
      prev_q <= cur_q;
    end
  end

  assign EDGE_O = cur_q & ~prev_q;

endmodule

// File: rtl/fp32_mac_sequencer.sv
// Byte-stream front/back end for the FP32 MAC: gathers 12 RX bytes into the
// alpha/bravo/acc operands, launches the MAC, waits for its result and sends
// the 32-bit result out as 4 little-endian bytes.
module fp32_mac_sequencer #(
  parameter int RX_GAP_CYCLES = 100000,
  parameter int DONE_TIMEOUT  = 1023,
  parameter int FIRE_CYCLES   = 2
) (
  input  logic        CLK_I,
  input  logic        RSTL_I,
  input  logic [7:0]  RX_DATA_I,
  input  logic        RX_VALID_I,
  output logic [31:0] ALPHA_O,
  output logic [31:0] BRAVO_O,
  output logic [31:0] ACC_O,
  output logic        MAC_VALID_O,
  input  logic        MAC_DONE_I,
  input  logic [31:0] RESULT_I,
  output logic [7:0]  TX_DATA_O,
  output logic        TX_START_O,
  input  logic        TX_BUSY_I,
  output logic        BUSY_O,
  output logic        ERR_TIMEOUT_O,
  output logic        ERR_OVERRUN_O
);

  import fp32_seq_pkg::*;

  localparam int GAP_W  = $clog2(RX_GAP_CYCLES + 1);
  localparam int TO_W   = $clog2(DONE_TIMEOUT + 1);
  localparam int FIRE_W = $clog2(FIRE_CYCLES + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RX_GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(FIRE_CYCLES);
  localparam logic [3:0]        IDX_LAST  = 4'(OPERAND_BYTES - 1);
  localparam logic [1:0]        TX_LAST   = 2'(RESULT_BYTES - 1);

  seq_state_e        state_q;
  logic [3:0]        idx_q;
  logic [GAP_W-1:0]  gapCnt_q;
  logic [FIRE_W-1:0] fireCnt_q;
  logic [TO_W-1:0]   toCnt_q;
  logic [1:0]        txCnt_q;
  logic              waitSkip_q;
  logic [31:0]       result_q;
  logic [31:0]       alpha_q;
  logic [31:0]       bravo_q;
  logic [31:0]       acc_q;
  logic              macValid_q;
  logic [7:0]        txData_q;
  logic              txStart_q;
  logic              busy_q;
  logic              errTimeout_q;
  logic              errOverrun_q;
  logic              doneEdge;

  posedge_detector u_doneEdge (
    .CLK_I  (CLK_I),
    .RSTL_I (RSTL_I),
    .SIG_I  (MAC_DONE_I),
    .EDGE_O (doneEdge)
  );

  // Main sequencer: byte collection, MAC launch, result wait and byte-wise transmit.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_q      <= COLLECT;
      idx_q        <= '0;
      gapCnt_q     <= '0;
      fireCnt_q    <= '0;
      toCnt_q      <= '0;
      txCnt_q      <= '0;
      waitSkip_q   <= 1'b0;
      result_q     <= '0;
      alpha_q      <= '0;
      bravo_q      <= '0;
      acc_q        <= '0;
      macValid_q   <= 1'b0;
      txData_q     <= '0;
      txStart_q    <= 1'b0;
      busy_q       <= 1'b0;
      errTimeout_q <= 1'b0;
      errOverrun_q <= 1'b0;
    end else begin
      txStart_q <= 1'b0;

      if (RX_VALID_I && (state_q != COLLECT)) begin
        errOverrun_q <= 1'b1;
      end

      case (state_q)
        COLLECT: begin
          if (RX_VALID_I) begin
            case (idx_q[3:2])
              2'd0:    alpha_q[{idx_q[1:0], 3'b000} +: 8] <= RX_DATA_I;
              2'd1:    bravo_q[{idx_q[1:0], 3'b000} +: 8] <= RX_DATA_I;
              default: acc_q[{idx_q[1:0], 3'b000} +: 8]   <= RX_DATA_I;
            endcase
            gapCnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              idx_q     <= '0;
              fireCnt_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= FIRE;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else if (idx_q != 4'd0) begin
            if (gapCnt_q == GAP_LAST) begin
              idx_q    <= '0;
              gapCnt_q <= '0;
            end else begin
              gapCnt_q <= gapCnt_q + GAP_W'(1);
            end
          end
        end

        FIRE: begin
          if (fireCnt_q == FIRE_LAST) begin
            macValid_q <= 1'b0;
            toCnt_q    <= '0;
            state_q    <= WAIT_DONE;
          end else begin
            macValid_q <= 1'b1;
            fireCnt_q  <= fireCnt_q + FIRE_W'(1);
          end
        end

        WAIT_DONE: begin
          if (doneEdge) begin
            result_q <= RESULT_I;
            state_q  <= SEND;
          end else if (toCnt_q == TO_LAST) begin
            result_q     <= FP32_QNAN;
            errTimeout_q <= 1'b1;
            state_q      <= SEND;
          end else begin
            toCnt_q <= toCnt_q + TO_W'(1);
          end
        end

        SEND: begin
          if (!TX_BUSY_I) begin
            txData_q   <= result_q[7:0];
            txStart_q  <= 1'b1;
            waitSkip_q <= 1'b1;
            state_q    <= WAIT_TX;
          end
        end

        WAIT_TX: begin
          if (waitSkip_q) begin
            waitSkip_q <= 1'b0;
          end else if (!TX_BUSY_I) begin
            result_q <= {8'h00, result_q[31:8]};
            if (txCnt_q == TX_LAST) begin
              txCnt_q <= '0;
              busy_q  <= 1'b0;
              state_q <= COLLECT;
            end else begin
              txCnt_q <= txCnt_q + 2'd1;
              state_q <= SEND;
            end
          end
        end

        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign ALPHA_O       = alpha_q;
  assign BRAVO_O       = bravo_q;
  assign ACC_O         = acc_q;
  assign MAC_VALID_O   = macValid_q;
  assign TX_DATA_O     = txData_q;
  assign TX_START_O    = txStart_q;
  assign BUSY_O        = busy_q;
  assign ERR_TIMEOUT_O = errTimeout_q;
  assign ERR_OVERRUN_O = errOverrun_q;

endmodule

// File: tb/tb_fp32_mac_sequencer.sv
// Self-checking bench for fp32_mac_sequencer with behavioural MAC and UART TX models.
module tb_fp32_mac_sequencer;

  localparam int GAP   = 20;
  localparam int TOUT  = 40;
  localparam int FIREC = 2;

  logic        CLK_I = 1'b0;
  logic        RSTL_I = 1'b0;
  logic [7:0]  RX_DATA_I = '0;
  logic        RX_VALID_I = 1'b0;
  logic [31:0] ALPHA_O, BRAVO_O, ACC_O;
  logic        MAC_VALID_O;
  logic        MAC_DONE_I = 1'b0;
  logic [31:0] RESULT_I = '0;
  logic [7:0]  TX_DATA_O;
  logic        TX_START_O;
  logic        TX_BUSY_I = 1'b0;
  logic        BUSY_O, ERR_TIMEOUT_O, ERR_OVERRUN_O;

  fp32_mac_sequencer #(
    .RX_GAP_CYCLES (GAP),
    .DONE_TIMEOUT  (TOUT),
    .FIRE_CYCLES   (FIREC)
  ) dut (
    .CLK_I         (CLK_I),
    .RSTL_I        (RSTL_I),
    .RX_DATA_I     (RX_DATA_I),
    .RX_VALID_I    (RX_VALID_I),
    .ALPHA_O       (ALPHA_O),
    .BRAVO_O       (BRAVO_O),
    .ACC_O         (ACC_O),
    .MAC_VALID_O   (MAC_VALID_O),
    .MAC_DONE_I    (MAC_DONE_I),
    .RESULT_I      (RESULT_I),
    .TX_DATA_O     (TX_DATA_O),
    .TX_START_O    (TX_START_O),
    .TX_BUSY_I     (TX_BUSY_I),
    .BUSY_O        (BUSY_O),
    .ERR_TIMEOUT_O (ERR_TIMEOUT_O),
    .ERR_OVERRUN_O (ERR_OVERRUN_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [95:0] rxSeq;
    logic [31:0] macResult;
    logic [31:0] expAlpha;
    logic [31:0] expBravo;
    logic [31:0] expAcc;
    logic [31:0] expTxSeq;
  } vec_t;

  vec_t vecs [3];

  int checks = 0;
  int errors = 0;

  int          launches = 0;
  int          lastValidWidth = 0;
  int          curValidWidth = 0;
  int          macLatency = 3;
  bit          macNeverDone = 1'b0;
  logic [31:0] macResult = '0;
  logic [31:0] capA = '0, capB = '0, capC = '0;
  bit          macPrevValid = 1'b0;
  bit          macPending = 1'b0;
  int          macCountdown = 0;

  logic [7:0]  txQ [$];
  int          txBusyLen = 3;
  bit          txForceBusy = 1'b0;
  int          txBusyCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutputBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: byte i of a frame, operand word w, and result byte order on the wire.
  function automatic logic [7:0] seqByte(input logic [95:0] s, input int i);
    return s[95 - 8*i -: 8];
  endfunction

  function automatic logic [31:0] opWord(input logic [95:0] s, input int w);
    return {seqByte(s, 4*w + 3), seqByte(s, 4*w + 2), seqByte(s, 4*w + 1), seqByte(s, 4*w)};
  endfunction

  function automatic logic [31:0] txOrder(input logic [31:0] r);
    return {r[7:0], r[15:8], r[23:16], r[31:24]};
  endfunction

  function automatic vec_t randVec();
    vec_t v;
    v.rxSeq     = {$urandom, $urandom, $urandom};
    v.macResult = $urandom;
    v.expAlpha  = opWord(v.rxSeq, 0);
    v.expBravo  = opWord(v.rxSeq, 1);
    v.expAcc    = opWord(v.rxSeq, 2);
    v.expTxSeq  = txOrder(v.macResult);
    return v;
  endfunction

  function automatic logic [31:0] txGot();
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < txQ.size()) r[31 - 8*i -: 8] = txQ[i];
    end
    return r;
  endfunction

  // MAC model: on a launch, drops done, waits a latency after valid falls, then returns the result.
  initial begin
    forever begin
      @(negedge CLK_I);
      if (!RSTL_I) begin
        macPrevValid  = 1'b0;
        macPending    = 1'b0;
        curValidWidth = 0;
      end else begin
        if (MAC_VALID_O && !macPrevValid) begin
          launches++;
          capA = ALPHA_O;
          capB = BRAVO_O;
          capC = ACC_O;
          MAC_DONE_I    = 1'b0;
          macPending    = 1'b1;
          macCountdown  = macLatency;
          curValidWidth = 0;
        end
        if (MAC_VALID_O) begin
          curValidWidth++;
        end else begin
          if (macPrevValid) lastValidWidth = curValidWidth;
          if (macPending) begin
            if (macCountdown == 0) begin
              macPending = 1'b0;
              if (!macNeverDone) begin
                RESULT_I   = macResult;
                MAC_DONE_I = 1'b1;
              end
            end else begin
              macCountdown--;
            end
          end
        end
        macPrevValid = MAC_VALID_O;
      end
    end
  end

  // UART TX model: records each started byte and reports busy for a while after it.
  initial begin
    forever begin
      @(negedge CLK_I);
      if (!RSTL_I) begin
        txBusyCnt = 0;
      end else if (TX_START_O) begin
        checkOutputBit("start while busy", TX_BUSY_I, 1'b0);
        txQ.push_back(TX_DATA_O);
        txBusyCnt = txBusyLen;
      end else if (txBusyCnt > 0) begin
        txBusyCnt--;
      end
      TX_BUSY_I = (txBusyCnt != 0) || txForceBusy;
    end
  end

  task automatic tick();
    @(negedge CLK_I);
    #1;
  endtask

  task automatic applyStimulus(input logic [95:0] seq, input int nBytes, input int gapMax);
    for (int i = 0; i < nBytes; i++) begin
      RX_DATA_I  = seqByte(seq, i);
      RX_VALID_I = 1'b1;
      tick();
      RX_VALID_I = 1'b0;
      if (i < nBytes - 1) repeat ($urandom_range(gapMax, 0)) tick();
    end
  endtask

  task automatic waitLaunch(input string tag, input int target);
    int n = 0;
    while (launches < target && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, " launch seen"}, 32'(launches), 32'(target));
  endtask

  task automatic waitTx(input string tag, input int target, input int budget);
    int n = 0;
    while (txQ.size() < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, " tx count"}, 32'(txQ.size()), 32'(target));
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (BUSY_O && n < 300) begin
      tick();
      n++;
    end
    checkOutputBit({tag, " idle"}, BUSY_O, 1'b0);
  endtask

  task automatic checkOperands(input string tag, input vec_t v);
    checkOutput({tag, " alpha"}, capA, v.expAlpha);
    checkOutput({tag, " bravo"}, capB, v.expBravo);
    checkOutput({tag, " acc"}, capC, v.expAcc);
  endtask

  task automatic checkFrame(input vec_t v, input string tag);
    int l0;
    txQ.delete();
    macResult = v.macResult;
    l0 = launches;
    applyStimulus(v.rxSeq, 12, 2);
    checkOutputBit({tag, " valid early"}, MAC_VALID_O, 1'b0);
    checkOutputBit({tag, " busy"}, BUSY_O, 1'b1);
    tick();
    checkOutputBit({tag, " valid rise"}, MAC_VALID_O, 1'b1);
    waitLaunch(tag, l0 + 1);
    checkOperands(tag, v);
    waitTx(tag, 4, 300);
    checkOutput({tag, " valid width"}, 32'(lastValidWidth), 32'(FIREC));
    checkOutput({tag, " tx bytes"}, txGot(), v.expTxSeq);
    waitIdle(tag);
    repeat (3) tick();
    checkOutput({tag, " launches"}, 32'(launches), 32'(l0 + 1));
    checkOutput({tag, " tx total"}, 32'(txQ.size()), 32'd4);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ALPHA_O"}, ALPHA_O, 32'h0);
    checkOutput({tag, " BRAVO_O"}, BRAVO_O, 32'h0);
    checkOutput({tag, " ACC_O"}, ACC_O, 32'h0);
    checkOutputBit({tag, " MAC_VALID_O"}, MAC_VALID_O, 1'b0);
    checkOutput({tag, " TX_DATA_O"}, 32'(TX_DATA_O), 32'h0);
    checkOutputBit({tag, " TX_START_O"}, TX_START_O, 1'b0);
    checkOutputBit({tag, " BUSY_O"}, BUSY_O, 1'b0);
    checkOutputBit({tag, " ERR_TIMEOUT_O"}, ERR_TIMEOUT_O, 1'b0);
    checkOutputBit({tag, " ERR_OVERRUN_O"}, ERR_OVERRUN_O, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end expected end of test");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vec_t v;
    int l0;

    vecs[0] = '{96'h0000803F_00000040_00004040, 32'h40A00000,
                32'h3F800000, 32'h40000000, 32'h40400000, 32'h0000A040};
    vecs[1] = '{96'h01020304_05060708_090A0B0C, 32'h12345678,
                32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h78563412};
    vecs[2] = '{96'hFFEEDDCC_BBAA9988_77665544, 32'hDEADBEEF,
                32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'hEFBEADDE};

    RSTL_I = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    RSTL_I = 1'b1;
    tick();

    for (int k = 0; k < 3; k++) begin
      checkFrame(vecs[k], $sformatf("vec%0d", k));
    end

    // Partial frame abandoned by the gap timer, then a full frame.
    $display("[TB] gap discard");
    l0 = launches;
    applyStimulus({$urandom, $urandom, $urandom}, 5, 0);
    repeat (GAP + 1) tick();
    checkOutput("gap no launch", 32'(launches), 32'(l0));
    checkOutputBit("gap not busy", BUSY_O, 1'b0);
    checkFrame(randVec(), "after gap");

    // Byte arriving while waiting for the MAC.
    $display("[TB] overrun");
    checkOutputBit("overrun clear", ERR_OVERRUN_O, 1'b0);
    v = randVec();
    macLatency = 12;
    macResult = v.macResult;
    txQ.delete();
    l0 = launches;
    applyStimulus(v.rxSeq, 12, 0);
    waitLaunch("overrun", l0 + 1);
    repeat (5) tick();
    RX_DATA_I  = ~seqByte(v.rxSeq, 0);
    RX_VALID_I = 1'b1;
    tick();
    RX_VALID_I = 1'b0;
    tick();
    checkOutputBit("overrun flag", ERR_OVERRUN_O, 1'b1);
    checkOutput("overrun alpha", ALPHA_O, v.expAlpha);
    checkOutput("overrun bravo", BRAVO_O, v.expBravo);
    checkOutput("overrun acc", ACC_O, v.expAcc);
    waitTx("overrun", 4, 300);
    checkOutput("overrun tx bytes", txGot(), v.expTxSeq);
    waitIdle("overrun");
    macLatency = 3;
    checkFrame(randVec(), "after overrun");

    // MAC never answers: the qNaN is sent and the error is flagged.
    $display("[TB] done timeout");
    v = randVec();
    macNeverDone = 1'b1;
    macResult = v.macResult;
    txQ.delete();
    l0 = launches;
    applyStimulus(v.rxSeq, 12, 0);
    waitLaunch("timeout", l0 + 1);
    repeat (TOUT / 2) tick();
    checkOutputBit("timeout not early", ERR_TIMEOUT_O, 1'b0);
    checkOutput("timeout no early tx", 32'(txQ.size()), 32'd0);
    waitTx("timeout", 4, TOUT + 300);
    checkOutputBit("timeout flag", ERR_TIMEOUT_O, 1'b1);
    checkOutput("timeout tx bytes", txGot(), 32'h0000C07F);
    waitIdle("timeout");
    macNeverDone = 1'b0;

    // Transmitter held busy for 50 cycles while the result is pending.
    $display("[TB] tx busy hold");
    v = randVec();
    macResult = v.macResult;
    txQ.delete();
    l0 = launches;
    applyStimulus(v.rxSeq, 12, 0);
    txForceBusy = 1'b1;
    waitLaunch("busyhold", l0 + 1);
    repeat (50) tick();
    checkOutput("busyhold no start", 32'(txQ.size()), 32'd0);
    txForceBusy = 1'b0;
    waitTx("busyhold", 4, 300);
    checkOutput("busyhold tx bytes", txGot(), v.expTxSeq);
    waitIdle("busyhold");
    repeat (3) tick();
    checkOutput("busyhold starts", 32'(txQ.size()), 32'd4);

    // Randomized frames against the reference model.
    for (int k = 0; k < 6; k++) begin
      macLatency = int'($urandom_range(8, 0));
      txBusyLen  = int'($urandom_range(6, 1));
      checkFrame(randVec(), $sformatf("rand%0d", k));
    end
    macLatency = 3;
    txBusyLen  = 3;

    // Reset asserted while the first result byte is on its way out.
    $display("[TB] reset in WAIT_TX");
    v = randVec();
    macResult = 32'hA5C31E77;
    txQ.delete();
    l0 = launches;
    applyStimulus(v.rxSeq, 12, 0);
    waitLaunch("midreset", l0 + 1);
    waitTx("midreset", 1, 300);
    checkOutput("midreset first byte", 32'(txQ[0]), 32'h77);
    #1;
    RSTL_I = 1'b0;
    #1;
    checkAllZero("midreset");
    tick();
    tick();
    RSTL_I = 1'b1;
    tick();
    txQ.delete();
    checkFrame(randVec(), "post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
